// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC receive types and Ethernet frame length limits
package mac_pkg;

  typedef enum logic [1:0] {IDLE, FWD, DROP} rx_state_t;

  typedef logic [15:0] len_t;
  typedef logic [31:0] stat_cnt_t;

  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_MAX_LEN = 1514;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-high reset
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - MAC receive frame sequencer: admission, framing/length checks, stats
module rx_frame_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = ETH_MIN_LEN,
  parameter int MAX_LEN    = ETH_MAX_LEN,
  parameter int LEN_WIDTH  = $bits(len_t),
  parameter int CNT_WIDTH  = $bits(stat_cnt_t)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic                  stream_in_startofpacket,
  input  logic                  stream_in_endofpacket,
  input  logic                  stream_in_valid,
  input  logic [DATA_WIDTH-1:0] stream_in_data,
  input  logic                  stream_in_error,
  output logic                  stream_out_startofpacket,
  output logic                  stream_out_endofpacket,
  output logic                  stream_out_valid,
  output logic [DATA_WIDTH-1:0] stream_out_data,
  output logic                  stream_out_error,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_valid,
  output logic [CNT_WIDTH-1:0]  stat_frames_ok,
  output logic [CNT_WIDTH-1:0]  stat_frames_err,
  output logic [CNT_WIDTH-1:0]  stat_frames_drop,
  output logic                  busy
);

  localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE_L = LEN_WIDTH'(1);
  // A single-beat frame is judged against the same limits as any other frame.
  localparam logic ONE_BEAT_BAD = (ONE_L < MIN_L) || (ONE_L > MAX_L);

  rx_state_t             state;
  logic                  hold_valid;
  logic                  hold_sop;
  logic                  hold_eop;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [LEN_WIDTH-1:0]  len;
  logic                  err;

  logic [LEN_WIDTH-1:0]  len_inc;
  logic                  eop_err;
  logic                  emit_eop;
  logic                  trunc;
  logic                  ok_inc;
  logic                  err_inc;
  logic                  drop_inc;

  always_comb begin
    len_inc  = (len == '1) ? len : len + 1'b1;
    eop_err  = err | stream_in_error | (len_inc < MIN_L) | (len_inc > MAX_L);
    // A held EOP beat only exists while IDLE, so it never coincides with a truncation.
    emit_eop = hold_valid & hold_eop;
    trunc    = (state == FWD) & stream_in_valid & stream_in_startofpacket;
    ok_inc   = emit_eop & ~err;
    err_inc  = (emit_eop & err) | trunc;
    drop_inc = stream_in_valid &
               (((state == DROP) & (stream_in_endofpacket | stream_in_startofpacket)) |
                (stream_in_startofpacket & stream_in_endofpacket & ~cfg_enable));
  end

  assign busy = (state != IDLE) | hold_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      hold_valid               <= 1'b0;
      hold_sop                 <= 1'b0;
      hold_eop                 <= 1'b0;
      hold_data                <= '0;
      len                      <= '0;
      err                      <= 1'b0;
      stream_out_valid         <= 1'b0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_error         <= 1'b0;
      stream_out_data          <= '0;
      frame_len                <= '0;
      frame_len_valid          <= 1'b0;
    end else begin
      stream_out_valid         <= 1'b0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_error         <= 1'b0;
      stream_out_data          <= '0;
      frame_len_valid          <= 1'b0;

      if (emit_eop) begin
        stream_out_valid         <= 1'b1;
        stream_out_startofpacket <= hold_sop;
        stream_out_endofpacket   <= 1'b1;
        stream_out_error         <= err;
        stream_out_data          <= hold_data;
        frame_len                <= len;
        frame_len_valid          <= 1'b1;
        hold_valid               <= 1'b0;
        hold_eop                 <= 1'b0;
      end

      if (stream_in_valid) begin
        case (state)
          FWD: begin
            stream_out_valid         <= 1'b1;
            stream_out_startofpacket <= hold_sop;
            stream_out_data          <= hold_data;
            if (stream_in_startofpacket) begin
              // Missing EOP: close the frame on the held beat as an errored frame.
              stream_out_endofpacket <= 1'b1;
              stream_out_error       <= 1'b1;
              frame_len              <= len;
              frame_len_valid        <= 1'b1;
              hold_valid             <= 1'b0;
              state                  <= IDLE;
            end else begin
              hold_data <= stream_in_data;
              hold_sop  <= 1'b0;
              hold_eop  <= stream_in_endofpacket;
              len       <= len_inc;
              if (stream_in_endofpacket) begin
                err   <= eop_err;
                state <= IDLE;
              end else begin
                err <= err | stream_in_error;
              end
            end
          end
          DROP: begin
            if (stream_in_endofpacket || stream_in_startofpacket) begin
              state <= IDLE;
            end
          end
          default: ;
        endcase

        // SOP evaluation is shared by IDLE, truncation in FWD and restart in DROP.
        if (stream_in_startofpacket) begin
          if (cfg_enable) begin
            hold_valid <= 1'b1;
            hold_sop   <= 1'b1;
            hold_eop   <= stream_in_endofpacket;
            hold_data  <= stream_in_data;
            len        <= ONE_L;
            if (stream_in_endofpacket) begin
              err   <= stream_in_error | ONE_BEAT_BAD;
              state <= IDLE;
            end else begin
              err   <= stream_in_error;
              state <= FWD;
            end
          end else begin
            state <= stream_in_endofpacket ? IDLE : DROP;
          end
        end
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_ok (
    .clk   (clk),
    .rst   (rst),
    .inc   (ok_inc),
    .count (stat_frames_ok)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_err (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (stat_frames_err)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_drop (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (stat_frames_drop)
  );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - directed frame vectors and corner sequences for rx_frame_ctrl
module tb_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic        stream_in_startofpacket = 1'b0;
  logic        stream_in_endofpacket = 1'b0;
  logic        stream_in_valid = 1'b0;
  logic [7:0]  stream_in_data = '0;
  logic        stream_in_error = 1'b0;
  logic        stream_out_startofpacket;
  logic        stream_out_endofpacket;
  logic        stream_out_valid;
  logic [7:0]  stream_out_data;
  logic        stream_out_error;
  logic [15:0] frame_len;
  logic        frame_len_valid;
  logic [31:0] stat_frames_ok;
  logic [31:0] stat_frames_err;
  logic [31:0] stat_frames_drop;
  logic        busy;

  always #5 clk = ~clk;

  rx_frame_ctrl dut (
    .clk                      (clk),
    .rst                      (rst),
    .cfg_enable               (cfg_enable),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_valid          (stream_in_valid),
    .stream_in_data           (stream_in_data),
    .stream_in_error          (stream_in_error),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_valid         (stream_out_valid),
    .stream_out_data          (stream_out_data),
    .stream_out_error         (stream_out_error),
    .frame_len                (frame_len),
    .frame_len_valid          (frame_len_valid),
    .stat_frames_ok           (stat_frames_ok),
    .stat_frames_err          (stat_frames_err),
    .stat_frames_drop         (stat_frames_drop),
    .busy                     (busy)
  );

  int checks = 0;
  int errors = 0;
  int inv_bad = 0;

  logic [7:0] q_data[$];
  bit         q_sop[$];
  bit         q_eop[$];
  bit         q_err[$];
  int         q_len[$];

  // Output monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (stream_out_valid) begin
      q_data.push_back(stream_out_data);
      q_sop.push_back(stream_out_startofpacket);
      q_eop.push_back(stream_out_endofpacket);
      q_err.push_back(stream_out_error);
    end
    if (frame_len_valid) q_len.push_back(int'(frame_len));
    if (!stream_out_valid && (stream_out_startofpacket || stream_out_endofpacket || stream_out_error))
      inv_bad++;
    if (frame_len_valid && !(stream_out_valid && stream_out_endofpacket)) inv_bad++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input bit s, input bit e, input int d, input bit er, input bit en);
    @(negedge clk);
    stream_in_valid         = 1'b1;
    stream_in_startofpacket = s;
    stream_in_endofpacket   = e;
    stream_in_data          = 8'(d);
    stream_in_error         = er;
    cfg_enable              = en;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      stream_in_valid         = 1'b0;
      stream_in_startofpacket = 1'b0;
      stream_in_endofpacket   = 1'b0;
      stream_in_error         = 1'b0;
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_sop.delete(); q_eop.delete(); q_err.delete(); q_len.delete();
  endtask

  // Counts beats whose data, SOP/EOP placement or error flag breaks in-order framing.
  function automatic int order_bad(input int eop_at_a);
    int nb = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      bit last = (i == q_data.size() - 1) || (i == eop_at_a);
      if (q_data[i] != 8'(i)) nb++;
      if (q_sop[i] != ((i == 0) || (i == eop_at_a + 1))) nb++;
      if (q_eop[i] != last) nb++;
      if (q_err[i] && !last) nb++;
    end
    return nb;
  endfunction

  typedef struct {
    int len;
    int err_beat;
    int gap;
    bit en;
    int exp_beats;
    bit exp_err;
    int exp_len;
    int d_ok;
    int d_err;
    int d_drop;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    longint s_ok, s_err, s_drop;

    vecs[0]  = '{64,   -1, 0, 1'b1, 64,   1'b0, 64,   1, 0, 0};
    vecs[1]  = '{10,   -1, 0, 1'b1, 10,   1'b1, 10,   0, 1, 0};
    vecs[2]  = '{1600, -1, 0, 1'b1, 1600, 1'b1, 1600, 0, 1, 0};
    vecs[3]  = '{80,    4, 0, 1'b1, 80,   1'b1, 80,   0, 1, 0};
    vecs[4]  = '{60,   -1, 0, 1'b1, 60,   1'b0, 60,   1, 0, 0};
    vecs[5]  = '{59,   -1, 0, 1'b1, 59,   1'b1, 59,   0, 1, 0};
    vecs[6]  = '{1514, -1, 0, 1'b1, 1514, 1'b0, 1514, 1, 0, 0};
    vecs[7]  = '{1515, -1, 0, 1'b1, 1515, 1'b1, 1515, 0, 1, 0};
    vecs[8]  = '{1,    -1, 0, 1'b1, 1,    1'b1, 1,    0, 1, 0};
    vecs[9]  = '{60,   -1, 7, 1'b1, 60,   1'b0, 60,   1, 0, 0};
    vecs[10] = '{20,   -1, 0, 1'b0, 0,    1'b0, 0,    0, 0, 1};

    rst = 1'b1;
    idle(3);
    check("reset out_valid", stream_out_valid, 0);
    check("reset out_flags", {stream_out_startofpacket, stream_out_endofpacket, stream_out_error}, 0);
    check("reset out_data", stream_out_data, 0);
    check("reset frame_len", frame_len, 0);
    check("reset frame_len_valid", frame_len_valid, 0);
    check("reset stat_ok", stat_frames_ok, 0);
    check("reset stat_err", stat_frames_err, 0);
    check("reset stat_drop", stat_frames_drop, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < NV; v++) begin
      s_ok = stat_frames_ok; s_err = stat_frames_err; s_drop = stat_frames_drop;
      clear_q();
      for (int i = 0; i < vecs[v].len; i++) begin
        if (vecs[v].gap > 0 && i > 0 && (i % vecs[v].gap) == 0) idle(2);
        beat(i == 0, i == vecs[v].len - 1, i, i == vecs[v].err_beat, vecs[v].en);
      end
      idle(4);
      check($sformatf("v%0d beats", v), q_data.size(), vecs[v].exp_beats);
      check($sformatf("v%0d len_strobes", v), q_len.size(), (vecs[v].exp_beats > 0) ? 1 : 0);
      if (vecs[v].exp_beats > 0) begin
        check($sformatf("v%0d order", v), order_bad(-2), 0);
        check($sformatf("v%0d eop_error", v), (q_err.size() > 0) ? q_err[$] : 1'bx, vecs[v].exp_err);
        check($sformatf("v%0d frame_len", v), (q_len.size() > 0) ? q_len[0] : -1, vecs[v].exp_len);
      end
      check($sformatf("v%0d d_ok", v), stat_frames_ok - s_ok, vecs[v].d_ok);
      check($sformatf("v%0d d_err", v), stat_frames_err - s_err, vecs[v].d_err);
      check($sformatf("v%0d d_drop", v), stat_frames_drop - s_drop, vecs[v].d_drop);
      check($sformatf("v%0d busy_after", v), busy, 0);
    end

    // Missing EOP: SOP on beat 31 truncates the first frame at 30 beats.
    s_ok = stat_frames_ok; s_err = stat_frames_err; s_drop = stat_frames_drop;
    clear_q();
    for (int i = 0; i < 70; i++) begin
      beat(i == 0 || i == 30, i == 69, i, 1'b0, 1'b1);
      if (i == 10) check("trunc busy_mid", busy, 1);
    end
    idle(4);
    check("trunc beats", q_data.size(), 70);
    check("trunc order", order_bad(29), 0);
    check("trunc beat30_eop", (q_eop.size() > 29) ? q_eop[29] : 1'bx, 1);
    check("trunc beat30_err", (q_err.size() > 29) ? q_err[29] : 1'bx, 1);
    check("trunc beat31_sop", (q_sop.size() > 30) ? q_sop[30] : 1'bx, 1);
    check("trunc len_strobes", q_len.size(), 2);
    check("trunc len_first", (q_len.size() > 0) ? q_len[0] : -1, 30);
    check("trunc len_second", (q_len.size() > 1) ? q_len[1] : -1, 40);
    check("trunc second_runt", (q_err.size() > 0) ? q_err[$] : 1'bx, 1);
    check("trunc d_err", stat_frames_err - s_err, 2);
    check("trunc d_ok", stat_frames_ok - s_ok, 0);

    // Disabled at SOP, enable raised mid-frame: still dropped.
    s_drop = stat_frames_drop;
    clear_q();
    for (int i = 0; i < 20; i++) beat(i == 0, i == 19, i, 1'b0, i >= 2);
    idle(4);
    check("drop beats", q_data.size(), 0);
    check("drop d_drop", stat_frames_drop - s_drop, 1);
    check("drop busy", busy, 0);

    // Forwarded frame interrupted by reset at beat 20.
    clear_q();
    for (int i = 0; i < 19; i++) beat(i == 0, 1'b0, i, 1'b0, 1'b1);
    check("rstmid busy_before", busy, 1);
    beat(1'b0, 1'b0, 19, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid beats_before", q_data.size(), 18);
    check("rstmid stat_ok", stat_frames_ok, 0);
    check("rstmid stat_err", stat_frames_err, 0);
    check("rstmid stat_drop", stat_frames_drop, 0);
    check("rstmid busy", busy, 0);
    check("rstmid out_valid", stream_out_valid, 0);
    rst = 1'b0;
    stream_in_data = 8'd20;
    for (int i = 21; i < 64; i++) beat(1'b0, i == 63, i, 1'b0, 1'b1);
    idle(4);
    check("rstmid beats_after", q_data.size(), 18);
    check("rstmid len_strobes", q_len.size(), 0);
    check("rstmid counters_after", stat_frames_ok + stat_frames_err + stat_frames_drop, 0);
    check("rstmid busy_after", busy, 0);

    check("invariants", inv_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
